// File: rtl/seg_status_panel_if.sv
`default_nettype none
// ============================================================================
// Module   : seg_status_panel_if
// Brief    : Monitor-to-panel bundle: PC, monitor state, interrupt vector in;
//            eight 7-segment digits and HALT/ERROR flags out.
// Revision : 1.0 - initial release
// ============================================================================
interface seg_status_panel_if #(
    parameter int DATA_WIDTH = 64
);
    logic [DATA_WIDTH-1:0] pc_i;
    logic [2:0]            nstate_i;
    logic [5:0]            interrupts_i;
    logic [7:0]            seg0;
    logic [7:0]            seg1;
    logic [7:0]            seg2;
    logic [7:0]            seg3;
    logic [7:0]            seg4;
    logic [7:0]            seg5;
    logic [7:0]            seg6;
    logic [7:0]            seg7;
    logic                  halted_o;
    logic                  error_o;

    modport master (
        output pc_i, nstate_i, interrupts_i,
        input  seg0, seg1, seg2, seg3, seg4, seg5, seg6, seg7, halted_o, error_o
    );

    modport slave (
        input  pc_i, nstate_i, interrupts_i,
        output seg0, seg1, seg2, seg3, seg4, seg5, seg6, seg7, halted_o, error_o
    );
endinterface
`default_nettype wire

// File: rtl/seg_status_panel.sv
`default_nettype none
// ============================================================================
// Module   : seg_status_panel
// Brief    : Eight-digit 7-segment status panel: rate-limited PC in RUN,
//            frozen PC in HALT, blinking anomaly code in ERROR.
// Revision : 1.0 - initial release
// ============================================================================
module seg_status_panel #(
    parameter int DATA_WIDTH     = 64,
    parameter int REFRESH_CYCLES = 1000,
    parameter int BLINK_CYCLES   = 25000
) (
    input wire logic          clk_i,
    input wire logic          rst_i,
    seg_status_panel_if.slave bus
);

    localparam int c_RW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam int c_BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    localparam logic [c_RW-1:0] c_REF_LAST   = c_RW'(REFRESH_CYCLES - 1);
    localparam logic [c_BW-1:0] c_BLINK_LAST = c_BW'(BLINK_CYCLES - 1);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_RUN   = 2'd1;
    localparam logic [1:0] c_ST_HALT  = 2'd2;
    localparam logic [1:0] c_ST_ERROR = 2'd3;

    logic [1:0]      r_state;
    logic [1:0]      w_state_next;
    logic [31:0]     r_snapshot;
    logic [c_RW-1:0] r_ref_cnt;
    logic [c_BW-1:0] r_blink_cnt;
    logic            r_blink_on;
    logic [3:0]      r_code;
    logic [3:0]      w_code;
    logic [7:0]      w_seg_next [8];
    logic [7:0]      r_seg      [8];
    logic            w_halted_next;
    logic            w_error_next;
    logic            r_halted;
    logic            r_error;
    logic            w_unused_irq;

    function automatic logic [7:0] f_hex(input logic [3:0] n);
        case (n)
            4'h0: f_hex = 8'hC0;
            4'h1: f_hex = 8'hF9;
            4'h2: f_hex = 8'hA4;
            4'h3: f_hex = 8'hB0;
            4'h4: f_hex = 8'h99;
            4'h5: f_hex = 8'h92;
            4'h6: f_hex = 8'h82;
            4'h7: f_hex = 8'hF8;
            4'h8: f_hex = 8'h80;
            4'h9: f_hex = 8'h90;
            4'hA: f_hex = 8'h88;
            4'hB: f_hex = 8'h83;
            4'hC: f_hex = 8'hC6;
            4'hD: f_hex = 8'hA1;
            4'hE: f_hex = 8'h86;
            default: f_hex = 8'h8E;
        endcase
    endfunction

    // Only the low word of the PC and the anomaly nibble are displayed.
    generate
        if (DATA_WIDTH > 32) begin : g_pc_wide
            logic w_unused_pc;
            assign w_unused_pc = ^bus.pc_i[DATA_WIDTH-1:32];
        end
    endgenerate
    assign w_unused_irq = ^bus.interrupts_i[5:4];

    always_comb begin
        casez (bus.interrupts_i[3:0])
            4'b???1: w_code = 4'h0;
            4'b??10: w_code = 4'h1;
            4'b?100: w_code = 4'h2;
            4'b1000: w_code = 4'h3;
            default: w_code = 4'hF;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // HALT and ERROR only leave through reset.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE, c_ST_RUN: begin
                case (bus.nstate_i)
                    3'd0:    w_state_next = c_ST_IDLE;
                    3'd1:    w_state_next = c_ST_RUN;
                    3'd2:    w_state_next = c_ST_HALT;
                    default: w_state_next = c_ST_ERROR;
                endcase
            end
            default: w_state_next = r_state;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_snapshot  <= 32'h0;
            r_ref_cnt   <= '0;
            r_blink_cnt <= '0;
            r_blink_on  <= 1'b1;
            r_code      <= 4'h0;
        end else begin
            case (r_state)
                c_ST_IDLE, c_ST_RUN: begin
                    if (w_state_next == c_ST_HALT) begin
                        r_snapshot <= bus.pc_i[31:0];
                    end else if (w_state_next == c_ST_ERROR) begin
                        r_code      <= w_code;
                        r_blink_cnt <= '0;
                        r_blink_on  <= 1'b1;
                    end else if (w_state_next == c_ST_RUN) begin
                        if (r_state == c_ST_IDLE || r_ref_cnt == c_REF_LAST) begin
                            r_snapshot <= bus.pc_i[31:0];
                            r_ref_cnt  <= '0;
                        end else begin
                            r_ref_cnt <= r_ref_cnt + 1'b1;
                        end
                    end
                end
                c_ST_ERROR: begin
                    if (r_blink_cnt == c_BLINK_LAST) begin
                        r_blink_cnt <= '0;
                        r_blink_on  <= ~r_blink_on;
                    end else begin
                        r_blink_cnt <= r_blink_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_halted_next = 1'b0;
        w_error_next  = 1'b0;
        for (int k = 0; k < 8; k++) begin
            w_seg_next[k] = 8'hFF;
        end
        case (r_state)
            c_ST_IDLE: begin
                for (int k = 0; k < 8; k++) begin
                    w_seg_next[k] = 8'hBF;
                end
            end
            c_ST_RUN, c_ST_HALT: begin
                for (int k = 0; k < 8; k++) begin
                    w_seg_next[k] = f_hex(r_snapshot[4*k +: 4]);
                end
                if (r_state == c_ST_HALT) begin
                    w_seg_next[0][7] = 1'b0;
                    w_halted_next    = 1'b1;
                end
            end
            default: begin
                w_error_next = 1'b1;
                if (r_blink_on) begin
                    w_seg_next[7] = 8'hB6;
                    w_seg_next[3] = f_hex(r_code);
                end
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int k = 0; k < 8; k++) begin
                r_seg[k] <= 8'hFF;
            end
            r_halted <= 1'b0;
            r_error  <= 1'b0;
        end else begin
            for (int k = 0; k < 8; k++) begin
                r_seg[k] <= w_seg_next[k];
            end
            r_halted <= w_halted_next;
            r_error  <= w_error_next;
        end
    end

    assign bus.seg0     = r_seg[0];
    assign bus.seg1     = r_seg[1];
    assign bus.seg2     = r_seg[2];
    assign bus.seg3     = r_seg[3];
    assign bus.seg4     = r_seg[4];
    assign bus.seg5     = r_seg[5];
    assign bus.seg6     = r_seg[6];
    assign bus.seg7     = r_seg[7];
    assign bus.halted_o = r_halted;
    assign bus.error_o  = r_error;

endmodule
`default_nettype wire

// File: tb/tb_seg_status_panel.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg_status_panel
// Brief    : Self-checking bench for seg_status_panel (REFRESH=4, BLINK=3).
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg_status_panel;

    localparam int R = 4;
    localparam int B = 3;
    localparam logic [7:0] GLYPH [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                          8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    seg_status_panel_if #(.DATA_WIDTH(64)) bus ();

    seg_status_panel #(
        .DATA_WIDTH    (64),
        .REFRESH_CYCLES(R),
        .BLINK_CYCLES  (B)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    logic [63:0] dut_segs;
    assign dut_segs = {bus.seg7, bus.seg6, bus.seg5, bus.seg4,
                       bus.seg3, bus.seg2, bus.seg1, bus.seg0};

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] show_hex(input logic [31:0] v);
        logic [63:0] r;
        for (int k = 0; k < 8; k++) r[8*k +: 8] = GLYPH[v[4*k +: 4]];
        return r;
    endfunction

    // Model: mode 0 idle, 1 run, 2 halt, 3 error. Outputs after an edge
    // reflect the mode/snapshot held before that edge.
    int          m_mode  = 0;
    logic [31:0] m_snap  = 32'h0;
    int          m_run_k = 0;
    int          m_err_k = 0;
    logic [3:0]  m_code  = 4'h0;
    bit          m_valid = 1'b0;
    logic [63:0] exp_segs = '1;
    logic        exp_halt = 1'b0;
    logic        exp_err  = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            exp_segs = '1;
            exp_halt = 1'b0;
            exp_err  = 1'b0;
            m_mode   = 0;
            m_snap   = 32'h0;
            m_valid  = 1'b1;
        end else begin
            exp_halt = (m_mode == 2);
            exp_err  = (m_mode == 3);
            case (m_mode)
                0: exp_segs = {8{8'hBF}};
                1: exp_segs = show_hex(m_snap);
                2: exp_segs = show_hex(m_snap) & ~64'h80;
                default: exp_segs = (((m_err_k / B) % 2) == 0)
                                    ? {8'hB6, 24'hFFFFFF, GLYPH[m_code], 24'hFFFFFF} : '1;
            endcase
            if (m_mode == 3) begin
                m_err_k++;
            end else if (m_mode != 2) begin
                case (bus.nstate_i)
                    3'd0: m_mode = 0;
                    3'd1: begin
                        if (m_mode == 0) begin
                            m_snap  = bus.pc_i[31:0];
                            m_run_k = 0;
                        end else begin
                            m_run_k++;
                            if (m_run_k % R == 0) m_snap = bus.pc_i[31:0];
                        end
                        m_mode = 1;
                    end
                    3'd2: begin
                        m_snap = bus.pc_i[31:0];
                        m_mode = 2;
                    end
                    default: begin
                        m_code = 4'hF;
                        for (int i = 3; i >= 0; i--) if (bus.interrupts_i[i]) m_code = 4'(i);
                        m_err_k = 0;
                        m_mode  = 3;
                    end
                endcase
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("model_segs", dut_segs, exp_segs);
            chk("model_halted", {63'h0, bus.halted_o}, {63'h0, exp_halt});
            chk("model_error", {63'h0, bus.error_o}, {63'h0, exp_err});
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) cyc();
        rst = 1'b0;
    endtask

    initial begin
        bus.pc_i         = 64'h0;
        bus.nstate_i     = 3'd0;
        bus.interrupts_i = 6'd0;

        do_reset(2);
        chk("reset_segs", dut_segs, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("reset_halted", {63'h0, bus.halted_o}, 64'h0);
        chk("reset_error", {63'h0, bus.error_o}, 64'h0);

        bus.nstate_i = 3'd0;
        cyc();
        cyc();
        chk("idle_dash", dut_segs, {8{8'hBF}});

        // RUN with junk in the upper PC word; entry captures 8000000C.
        bus.nstate_i = 3'd1;
        for (int i = 3; i < 16; i++) begin
            bus.pc_i = {32'hDEAD_BEEF, 32'h8000_0000 + 32'(4 * i)};
            cyc();
            if (i >= 4 && i <= 7) chk("run_hold_8000000C", dut_segs, 64'h80C0C0C0C0C0C0C6);
        end

        bus.nstate_i = 3'd0;
        cyc();
        cyc();
        chk("run_to_idle", dut_segs, {8{8'hBF}});

        bus.nstate_i = 3'd1;
        bus.pc_i     = 64'h0000_0000_8000_0100;
        repeat (3) cyc();
        bus.nstate_i = 3'd2;
        bus.pc_i     = 64'h0000_0000_8000_0124;
        cyc();
        bus.nstate_i = 3'd1;
        for (int i = 0; i < 6; i++) begin
            bus.pc_i = 64'h0000_0000_8000_0200 + 64'(i * 4);
            cyc();
        end
        // Digit 4 with its dp lit gives 8'h19 on seg0.
        chk("halt_frozen", dut_segs, 64'h80C0C0C0C0F9A419);
        chk("halt_flag", {63'h0, bus.halted_o}, 64'h1);
        chk("halt_no_error", {63'h0, bus.error_o}, 64'h0);

        do_reset(1);
        chk("reset_mid_halt", dut_segs, 64'hFFFF_FFFF_FFFF_FFFF);

        // HALT straight from IDLE; upper PC word ignored.
        bus.nstate_i = 3'd2;
        bus.pc_i     = 64'hFFFF_FFFF_1234_5670;
        cyc();
        bus.pc_i     = 64'h0;
        cyc();
        chk("halt_from_idle_dp", dut_segs, 64'hF9A4B0999282F840);

        do_reset(1);
        bus.nstate_i = 3'd1;
        bus.pc_i     = 64'h0000_0000_0000_ABCD;
        cyc();
        bus.nstate_i     = 3'd3;
        bus.interrupts_i = 6'b000110;
        cyc();
        bus.nstate_i     = 3'd1;
        bus.interrupts_i = 6'b000001;
        cyc();
        chk("err_on_code1", dut_segs, 64'hB6FFFFFFF9FFFFFF);
        chk("err_flag", {63'h0, bus.error_o}, 64'h1);
        cyc();
        cyc();
        cyc();
        chk("err_blink_off", dut_segs, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("err_flag_off_phase", {63'h0, bus.error_o}, 64'h1);
        repeat (3) cyc();
        chk("err_blink_on_again", dut_segs, 64'hB6FFFFFFF9FFFFFF);
        repeat (6) cyc();

        do_reset(1);
        chk("reset_mid_error", dut_segs, 64'hFFFF_FFFF_FFFF_FFFF);
        bus.nstate_i     = 3'd1;
        bus.interrupts_i = 6'd0;
        bus.pc_i         = 64'h0000_0000_0000_1111;
        repeat (3) cyc();
        chk("resume_run", dut_segs, 64'hC0C0C0C0F9F9F9F9);

        do_reset(1);
        bus.nstate_i     = 3'd5;
        bus.interrupts_i = 6'd0;
        cyc();
        bus.nstate_i = 3'd0;
        cyc();
        chk("illegal_code_F", dut_segs, 64'hB6FFFFFF8EFFFFFF);
        repeat (5) cyc();

        // Anomaly together with ECALL/EBREAK still latches the anomaly index.
        do_reset(1);
        bus.nstate_i     = 3'd3;
        bus.interrupts_i = 6'b110100;
        cyc();
        bus.nstate_i = 3'd2;
        cyc();
        chk("err_with_ecall", dut_segs, 64'hB6FFFFFFA4FFFFFF);
        repeat (4) cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
